wash_sequencer: RTL and testbench

//  Executes the wash program chosen by the mode selector. Latches model_now at start, steps WASH/RINSE/SPIN on 1 Hz ticks, drives actuators.

---
 rtl/wash_if.sv | 26 ++
 rtl/wash_sequencer.sv | 172 +++++++++++++++++
 tb/tb_wash_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wash_if.sv
// Selector/display-side signal bundle for the wash sequencer.
// master = mode selector / front panel, slave = wash_sequencer.
interface wash_if;
    logic       power_led;
    logic       start_pause;
    logic       sec_tick;
    logic [2:0] model_now;
    logic       if_finish;
    logic       busy;
    logic [1:0] stage;
    logic [7:0] time_left;
    logic       water_in;
    logic       motor;
    logic       drain;
    logic       buzzer;

    modport master (
        output power_led, start_pause, sec_tick, model_now,
        input  if_finish, busy, stage, time_left, water_in, motor, drain, buzzer
    );

    modport slave (
        input  power_led, start_pause, sec_tick, model_now,
        output if_finish, busy, stage, time_left, water_in, motor, drain, buzzer
    );
endinterface

// File: rtl/wash_sequencer.sv
// Wash program sequencer: steps WASH/RINSE/SPIN on 1 Hz ticks for the latched mode.
// Optional end-of-program buzzer is built only when BUZZER_EN is defined.
//   state  | meaning
//   IDLE   | no program, outputs quiet
//   WASH   | fill + agitate
//   RINSE  | fill + agitate
//   SPIN   | drain + spin
module wash_sequencer #(
    parameter int WASH_SEC  = 20,
    parameter int RINSE_SEC = 15,
    parameter int SPIN_SEC  = 10
`ifdef BUZZER_EN
    ,
    parameter int BUZZ_SEC  = 3
`endif
) (
    input  logic  clk,
    input  logic  reset,
    wash_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WASH  = 2'd1;
    localparam logic [1:0] ST_RINSE = 2'd2;
    localparam logic [1:0] ST_SPIN  = 2'd3;

    localparam logic [7:0] W_LEN = 8'(WASH_SEC);
    localparam logic [7:0] R_LEN = 8'(RINSE_SEC);
    localparam logic [7:0] S_LEN = 8'(SPIN_SEC);

    // Stage-enable mask per mode: bit2 = wash, bit1 = rinse, bit0 = spin.
    function automatic logic [2:0] stage_mask(input logic [2:0] mode);
        case (mode)
            3'd1:    return 3'b100;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [1:0] first_stage(input logic [2:0] mask);
        if (mask[2]) return ST_WASH;
        if (mask[1]) return ST_RINSE;
        return ST_SPIN;
    endfunction

    function automatic logic [1:0] next_stage(input logic [1:0] st, input logic [2:0] mask);
        case (st)
            ST_WASH:  return mask[1] ? ST_RINSE : (mask[0] ? ST_SPIN : ST_IDLE);
            ST_RINSE: return mask[0] ? ST_SPIN : ST_IDLE;
            default:  return ST_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] stage_len(input logic [1:0] st);
        case (st)
            ST_WASH:  return W_LEN;
            ST_RINSE: return R_LEN;
            ST_SPIN:  return S_LEN;
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] program_len(input logic [2:0] mask);
        return ({8{mask[2]}} & W_LEN) + ({8{mask[1]}} & R_LEN) + ({8{mask[0]}} & S_LEN);
    endfunction

    logic [1:0] state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [7:0] stage_cnt_q, stage_cnt_d;
    logic [7:0] time_left_q, time_left_d;
    logic       if_finish_q, if_finish_d;

    logic [2:0] start_mask;
    logic [2:0] run_mask;
    logic [1:0] start_stage;
    logic [1:0] adv_stage;
    logic       running;

    assign start_mask  = stage_mask(bus.model_now);
    assign run_mask    = stage_mask(mode_q);
    assign start_stage = first_stage(start_mask);
    assign adv_stage   = next_stage(state_q, run_mask);
    assign running     = (state_q != ST_IDLE) && bus.start_pause && bus.power_led;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stage_cnt_d = stage_cnt_q;
        time_left_d = time_left_q;
        if_finish_d = 1'b0;
        if (!bus.power_led) begin
            state_d     = ST_IDLE;
            stage_cnt_d = 8'd0;
            time_left_d = 8'd0;
        end else if (state_q == ST_IDLE) begin
            // A tick coinciding with the start is deliberately ignored.
            if (bus.start_pause) begin
                mode_d      = bus.model_now;
                state_d     = start_stage;
                stage_cnt_d = stage_len(start_stage);
                time_left_d = program_len(start_mask);
            end
        end else if (bus.start_pause && bus.sec_tick) begin
            time_left_d = time_left_q - 8'd1;
            if (stage_cnt_q == 8'd1) begin
                state_d     = adv_stage;
                stage_cnt_d = stage_len(adv_stage);
                if (adv_stage == ST_IDLE) begin
                    time_left_d = 8'd0;
                    if_finish_d = 1'b1;
                end
            end else begin
                stage_cnt_d = stage_cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 3'd0;
            stage_cnt_q <= 8'd0;
            time_left_q <= 8'd0;
            if_finish_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            stage_cnt_q <= stage_cnt_d;
            time_left_q <= time_left_d;
            if_finish_q <= if_finish_d;
        end
    end

    assign bus.if_finish = if_finish_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.stage     = state_q;
    assign bus.time_left = time_left_q;
    assign bus.water_in  = running && ((state_q == ST_WASH) || (state_q == ST_RINSE));
    assign bus.motor     = running;
    assign bus.drain     = running && (state_q == ST_SPIN);

`ifdef BUZZER_EN
    logic [7:0] buzz_cnt_q, buzz_cnt_d;

    always_comb begin
        buzz_cnt_d = buzz_cnt_q;
        if (!bus.power_led || ((state_q == ST_IDLE) && bus.start_pause)) begin
            buzz_cnt_d = 8'd0;
        end else if (if_finish_q) begin
            buzz_cnt_d = 8'(BUZZ_SEC);
        end else if (bus.sec_tick && (buzz_cnt_q != 8'd0)) begin
            buzz_cnt_d = buzz_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buzz_cnt_q <= 8'd0;
        end else begin
            buzz_cnt_q <= buzz_cnt_d;
        end
    end

    assign bus.buzzer = (buzz_cnt_q != 8'd0);
`else
    assign bus.buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: per-mode vector table plus hand-written pause,
// power-loss, reset and mode-change sequences. Buzzer checks follow BUZZER_EN.
module tb_wash_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wash_if bus ();

    wash_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        int         s0, s1, s2;
        int         l0, l1, l2;
        int         total;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_stage(input vec_t v, input int t);
        if (t < v.l0) return v.s0;
        if (t < v.l0 + v.l1) return v.s1;
        return v.s2;
    endfunction

    task automatic tick();
        bus.sec_tick = 1'b1;
        @(negedge clk);
        bus.sec_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.power_led   = 1'b0;
        bus.start_pause = 1'b0;
        bus.sec_tick    = 1'b0;
        bus.model_now   = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_stage", int'(bus.stage), 0);
        chk("rst_time", int'(bus.time_left), 0);
        chk("rst_fin", int'(bus.if_finish), 0);
        chk("rst_act", int'({bus.water_in, bus.motor, bus.drain, bus.buzzer}), 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_mode(input logic [2:0] m);
        bus.model_now   = m;
        bus.power_led   = 1'b1;
        bus.start_pause = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int st;
        do_reset();
        start_mode(v.mode);
        chk("start_stage", int'(bus.stage), v.s0);
        chk("start_time", int'(bus.time_left), v.total);
        chk("start_busy", int'(bus.busy), 1);
        for (int t = 1; t <= v.total; t++) begin
            tick();
            if (t < v.total) begin
                st = exp_stage(v, t);
                chk("run_time", int'(bus.time_left), v.total - t);
                chk("run_stage", int'(bus.stage), st);
                chk("run_fin", int'(bus.if_finish), 0);
                chk("run_water", int'(bus.water_in), (st == 1 || st == 2) ? 1 : 0);
                chk("run_motor", int'(bus.motor), 1);
                chk("run_drain", int'(bus.drain), (st == 3) ? 1 : 0);
            end else begin
                chk("end_fin", int'(bus.if_finish), 1);
                chk("end_busy", int'(bus.busy), 0);
                chk("end_time", int'(bus.time_left), 0);
                chk("end_stage", int'(bus.stage), 0);
                bus.start_pause = 1'b0;
            end
        end
        @(negedge clk);
        chk("post_fin", int'(bus.if_finish), 0);
        chk("post_busy", int'(bus.busy), 0);
`ifdef BUZZER_EN
        chk("buzz_on", int'(bus.buzzer), 1);
        tick();
        tick();
        chk("buzz_2", int'(bus.buzzer), 1);
        tick();
        chk("buzz_off", int'(bus.buzzer), 0);
`else
        chk("buzz_tied", int'(bus.buzzer), 0);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{3'd0, 1, 2, 3, 20, 15, 10, 45};
        vecs[1] = '{3'd1, 1, 0, 0, 20,  0,  0, 20};
        vecs[2] = '{3'd2, 1, 2, 0, 20, 15,  0, 35};
        vecs[3] = '{3'd3, 2, 0, 0, 15,  0,  0, 15};
        vecs[4] = '{3'd4, 2, 3, 0, 15, 10,  0, 25};
        vecs[5] = '{3'd5, 3, 0, 0, 10,  0,  0, 10};
        vecs[6] = '{3'd6, 1, 2, 3, 20, 15, 10, 45};
        vecs[7] = '{3'd7, 1, 2, 3, 20, 15, 10, 45};

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Tick coincident with start: start only.
        do_reset();
        bus.model_now   = 3'd5;
        bus.power_led   = 1'b1;
        bus.start_pause = 1'b1;
        bus.sec_tick    = 1'b1;
        @(negedge clk);
        bus.sec_tick = 1'b0;
        chk("tickstart_time", int'(bus.time_left), 10);
        chk("tickstart_stage", int'(bus.stage), 3);
        chk("tickstart_act", int'({bus.water_in, bus.motor, bus.drain}), 3);
        tick();
        chk("tickstart_dec", int'(bus.time_left), 9);

        // Start blocked while unpowered.
        do_reset();
        bus.start_pause = 1'b1;
        @(negedge clk);
        chk("nopower_busy", int'(bus.busy), 0);

        // Pause at tick 5 for 7 ticks, first paused tick coincides with the falling edge.
        do_reset();
        start_mode(3'd1);
        for (int t = 0; t < 5; t++) tick();
        chk("pre_pause_time", int'(bus.time_left), 15);
        bus.start_pause = 1'b0;
        tick();
        chk("pause_edge_time", int'(bus.time_left), 15);
        chk("pause_act", int'({bus.water_in, bus.motor, bus.drain}), 0);
        for (int t = 0; t < 6; t++) tick();
        chk("pause_hold_time", int'(bus.time_left), 15);
        chk("pause_hold_stage", int'(bus.stage), 1);
        chk("pause_busy", int'(bus.busy), 1);
        bus.start_pause = 1'b1;
        @(negedge clk);
        chk("resume_act", int'({bus.water_in, bus.motor, bus.drain}), 6);
        for (int t = 0; t < 14; t++) tick();
        chk("resume_time", int'(bus.time_left), 1);
        chk("resume_fin", int'(bus.if_finish), 0);
        tick();
        chk("resume_end_fin", int'(bus.if_finish), 1);
        bus.start_pause = 1'b0;

        // Mode change after start is ignored.
        do_reset();
        start_mode(3'd2);
        bus.model_now = 3'd4;
        for (int t = 0; t < 19; t++) tick();
        chk("mchg_stage_w", int'(bus.stage), 1);
        tick();
        chk("mchg_stage_r", int'(bus.stage), 2);
        chk("mchg_time", int'(bus.time_left), 15);
        for (int t = 0; t < 14; t++) tick();
        chk("mchg_fin0", int'(bus.if_finish), 0);
        tick();
        chk("mchg_fin1", int'(bus.if_finish), 1);
        bus.start_pause = 1'b0;

        // Power loss at tick 30 of mode 0.
        do_reset();
        start_mode(3'd0);
        for (int t = 0; t < 30; t++) tick();
        chk("pwr_pre_stage", int'(bus.stage), 2);
        chk("pwr_pre_time", int'(bus.time_left), 15);
        bus.power_led = 1'b0;
        #1;
        chk("pwr_act_now", int'({bus.water_in, bus.motor, bus.drain}), 0);
        @(negedge clk);
        chk("pwr_busy", int'(bus.busy), 0);
        chk("pwr_time", int'(bus.time_left), 0);
        chk("pwr_fin", int'(bus.if_finish), 0);
        @(negedge clk);
        chk("pwr_fin2", int'(bus.if_finish), 0);
        chk("pwr_buzz", int'(bus.buzzer), 0);

        // Reset mid-run.
        do_reset();
        start_mode(3'd0);
        for (int t = 0; t < 10; t++) tick();
        chk("mrst_pre_time", int'(bus.time_left), 35);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_time", int'(bus.time_left), 0);
        chk("mrst_fin", int'(bus.if_finish), 0);
        bus.start_pause = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_fin2", int'(bus.if_finish), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
